mvu_weight_streamer: RTL and testbench

//  Transmit side of the MVU weight stream. Holds one full weight matrix in an on-chip RAM,

---
 rtl/mvu_weight_streamer.sv | 207 ++++++++++++++++++++
 tb/tb_mvu_weight_streamer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mvu_weight_streamer.sv
// mvu_weight_streamer: holds one weight matrix in a local RAM and replays it
// NumReps times per start on an AXI-stream master feeding the MVU weight input.
// A two-entry output buffer (head + skid) absorbs the one-cycle RAM read latency
// so the stream runs at one beat per cycle when the consumer is always ready.
module mvu_weight_streamer #(
  parameter int PE      = 2,
  parameter int SIMD    = 2,
  parameter int TW      = 1,
  parameter int MatrixW = 8,
  parameter int MatrixH = 2,
  parameter int NumReps = 3,
  localparam int SF     = MatrixW / SIMD,
  localparam int NF     = MatrixH / PE,
  localparam int DEPTH  = SF * NF,
  localparam int WW     = PE * SIMD * TW,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [0:WW-1] cfg_wdata,
  output logic          cfg_ready,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [0:WW-1] m0_axis_tdata,
  output logic          m0_axis_tvalid,
  input  logic          m0_axis_tready
);

  localparam int RW = $clog2(NumReps + 1);
  localparam logic [AW:0]   DEPTH_L    = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [RW-1:0] LAST_REP   = RW'(NumReps - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_n_s;

  logic [0:WW-1] mem_r [0:DEPTH-1];
  logic [0:WW-1] ram_q_r;
  logic [0:WW-1] tdata_r;
  logic [0:WW-1] skid_r;
  logic          tvalid_r;
  logic          skid_valid_r;
  logic          inflight_r;
  logic          rd_done_r;
  logic          busy_r;
  logic          done_r;
  logic          cfg_ready_r;
  logic [AW-1:0] rd_addr_r;
  logic [RW-1:0] rep_r;

  logic          start_acc_s;
  logic          pop_s;
  logic          issue_s;
  logic          last_s;
  logic          wr_en_s;
  logic          addr_wrap_s;
  logic          rep_last_s;
  logic [2:0]    level_s;

  // Next-state and control decode: read issue gating, last-beat detection, start acceptance.
  always_comb begin
    state_n_s   = state_r;
    start_acc_s = 1'b0;
    issue_s     = 1'b0;
    last_s      = 1'b0;
    pop_s       = tvalid_r & m0_axis_tready;
    // Buffer occupancy after this cycle's pop, plus the read already in flight.
    level_s     = {2'b00, tvalid_r} + {2'b00, skid_valid_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    addr_wrap_s = (rd_addr_r == LAST_ADDR);
    rep_last_s  = (rep_r == LAST_REP);
    wr_en_s     = cfg_we && (state_r == IDLE) && ({1'b0, cfg_addr} < DEPTH_L);
    case (state_r)
      IDLE: begin
        // A start coinciding with the done pulse is deliberately dropped.
        if (start && !done_r) begin
          state_n_s   = RUN;
          start_acc_s = 1'b1;
        end else begin
          state_n_s   = IDLE;
        end
      end
      RUN: begin
        if (!rd_done_r && (level_s < 3'd2)) begin
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
        // The final beat is the head word once every read has landed and the skid is empty.
        if (pop_s && rd_done_r && !inflight_r && !skid_valid_r) begin
          last_s    = 1'b1;
          state_n_s = IDLE;
        end else begin
          last_s    = 1'b0;
          state_n_s = RUN;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Status flags and read-address / repetition counters.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cfg_ready_r <= 1'b1;
      inflight_r  <= 1'b0;
      rd_done_r   <= 1'b0;
      rd_addr_r   <= '0;
      rep_r       <= '0;
    end else begin
      done_r     <= last_s;
      inflight_r <= issue_s;
      if (start_acc_s) begin
        busy_r      <= 1'b1;
        cfg_ready_r <= 1'b0;
      end else if (last_s) begin
        busy_r      <= 1'b0;
        cfg_ready_r <= 1'b1;
      end
      if (start_acc_s) begin
        rd_addr_r <= '0;
        rep_r     <= '0;
        rd_done_r <= 1'b0;
      end else if (issue_s) begin
        if (addr_wrap_s) begin
          rd_addr_r <= '0;
          rep_r     <= rep_r + RW'(1);
          if (rep_last_s) begin
            rd_done_r <= 1'b1;
          end
        end else begin
          rd_addr_r <= rd_addr_r + AW'(1);
        end
      end
    end
  end

  // Weight RAM: config writes in IDLE, synchronous read in RUN; contents survive reset.
  always_ff @(posedge aclk) begin
    if (wr_en_s) begin
      mem_r[cfg_addr] <= cfg_wdata;
    end
    if (issue_s) begin
      ram_q_r <= mem_r[rd_addr_r];
    end
  end

  // Two-entry output buffer: head drives the stream, skid catches a read landing during a stall.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tdata_r      <= '0;
      tvalid_r     <= 1'b0;
      skid_r       <= '0;
      skid_valid_r <= 1'b0;
    end else begin
      if (pop_s) begin
        if (skid_valid_r) begin
          tdata_r <= skid_r;
          if (inflight_r) begin
            skid_r <= ram_q_r;
          end else begin
            skid_valid_r <= 1'b0;
          end
        end else if (inflight_r) begin
          tdata_r <= ram_q_r;
        end else begin
          tvalid_r <= 1'b0;
        end
      end else if (inflight_r) begin
        if (tvalid_r) begin
          skid_r       <= ram_q_r;
          skid_valid_r <= 1'b1;
        end else begin
          tdata_r  <= ram_q_r;
          tvalid_r <= 1'b1;
        end
      end
    end
  end

  assign m0_axis_tdata  = tdata_r;
  assign m0_axis_tvalid = tvalid_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign cfg_ready      = cfg_ready_r;

endmodule

// File: tb/tb_mvu_weight_streamer.sv
// Directed bench for mvu_weight_streamer: expected words are queued when a run is
// started and popped at every stream handshake.
module tb_mvu_weight_streamer;

  localparam int DEPTH = 4;
  localparam int WW    = 4;
  localparam int AW    = 2;
  localparam int NR    = 3;

  logic          aclk = 1'b0;
  logic          areset;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [0:WW-1] cfg_wdata;
  logic          cfg_ready;
  logic          start;
  logic          busy;
  logic          done;
  logic [0:WW-1] tdata;
  logic          tvalid;
  logic          tready;

  int n_cmp = 0;
  int n_err = 0;

  logic [0:WW-1] sb_q [$];
  logic [0:WW-1] img [0:DEPTH-1];

  mvu_weight_streamer dut (
    .aclk           (aclk),
    .areset         (areset),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_wdata      (cfg_wdata),
    .cfg_ready      (cfg_ready),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .m0_axis_tdata  (tdata),
    .m0_axis_tvalid (tvalid),
    .m0_axis_tready (tready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ready_pat(input int mode, input int c);
    case (mode)
      1:       ready_pat = (c >= 8 && c < 13) ? 1'b0 : ((c % 2) == 1);
      2:       ready_pat = (c > 10);
      default: ready_pat = 1'b1;
    endcase
  endfunction

  task automatic wr(input logic [AW-1:0] a, input logic [0:WW-1] d);
    @(negedge aclk);
    check("wr_cfg_ready", cfg_ready, 1'b1);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge aclk);
    cfg_we = 1'b0;
  endtask

  // One start-to-done run. mode picks the tready pattern; start_at / wr_at inject a
  // mid-run start or config write; rst_after aborts with areset after that many beats;
  // done_at (if >0) is the cycle index at which done must be seen.
  task automatic run(input int mode, input int start_at, input int wr_at,
                     input int rst_after, input int done_at, input string name);
    int            beats;
    bit            last_hs;
    bit            stalled;
    bit            rdy;
    logic [0:WW-1] held;
    logic [0:WW-1] exp_w;
    beats = 0; last_hs = 1'b0; stalled = 1'b0; held = '0;
    for (int r = 0; r < NR; r++)
      for (int a = 0; a < DEPTH; a++) sb_q.push_back(img[a]);
    for (int c = 0; c < 200; c++) begin
      @(negedge aclk);
      if (last_hs) begin
        check({name, "_done"}, done, 1'b1);
        check({name, "_busy_off"}, busy, 1'b0);
        check({name, "_cfg_ready_back"}, cfg_ready, 1'b1);
        check({name, "_tvalid_off"}, tvalid, 1'b0);
        check({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        if (done_at > 0) check({name, "_done_cycle"}, 32'(c), 32'(done_at));
        cfg_we = 1'b0;
        start  = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        check({name, "_start_on_done_ignored"}, busy, 1'b0);
        check({name, "_done_single"}, done, 1'b0);
        return;
      end
      if (rst_after > 0 && beats == rst_after) begin
        areset = 1'b1; start = 1'b0; cfg_we = 1'b0;
        #1;
        check({name, "_rst_tvalid"}, tvalid, 1'b0);
        check({name, "_rst_busy"}, busy, 1'b0);
        check({name, "_rst_cfg_ready"}, cfg_ready, 1'b1);
        @(negedge aclk);
        areset = 1'b0;
        sb_q.delete();
        return;
      end
      rdy       = ready_pat(mode, c);
      tready    = rdy;
      start     = (c == 0) || (c == start_at);
      cfg_we    = (c == wr_at);
      cfg_addr  = 2'd1;
      cfg_wdata = 4'hF;
      if (c > 0) begin
        if (stalled) begin
          check({name, "_hold_valid"}, tvalid, 1'b1);
          check({name, "_hold_data"}, tdata, held);
        end
        check({name, "_no_early_done"}, done, 1'b0);
        if (c == 1) begin
          check({name, "_busy_on"}, busy, 1'b1);
          check({name, "_cfg_ready_off"}, cfg_ready, 1'b0);
        end
        if (c == 2) check({name, "_lat_tvalid_low"}, tvalid, 1'b0);
        if (c == 3) check({name, "_lat_tvalid_high"}, tvalid, 1'b1);
        if (c == wr_at) check({name, "_cfg_ready_busy"}, cfg_ready, 1'b0);
      end
      if (tvalid && rdy) begin
        check({name, "_sb_avail"}, 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          exp_w = sb_q.pop_front();
          check({name, "_beat"}, tdata, exp_w);
        end
        beats++;
        if (beats == DEPTH * NR) last_hs = 1'b1;
      end
      stalled = tvalid && !rdy;
      held    = tdata;
    end
    check({name, "_beats_in_budget"}, 32'(beats), 32'(DEPTH * NR));
    start = 1'b0; cfg_we = 1'b0;
  endtask

  initial begin
    areset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    start = 1'b0; tready = 1'b0;
    repeat (2) @(negedge aclk);
    check("reset_tvalid", tvalid, 1'b0);
    check("reset_tdata", tdata, 4'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_cfg_ready", cfg_ready, 1'b1);
    areset = 1'b0;

    for (int a = 0; a < DEPTH; a++) begin
      img[a] = 4'(a + 1);
      wr(2'(a), img[a]);
    end

    run(0, -1, -1, 0, 15, "t1");
    run(1, -1, -1, 0, 0, "t2");
    run(0, -1, 5, 0, 15, "t3a");
    img[1] = 4'hF;
    wr(2'd1, 4'hF);
    run(0, -1, -1, 0, 15, "t3b");
    img[1] = 4'h2;
    wr(2'd1, 4'h2);
    run(0, 6, -1, 0, 15, "t4a");
    run(0, -1, -1, 0, 15, "t4b");
    run(0, -1, -1, 5, 0, "t5a");
    run(0, -1, -1, 0, 15, "t5b");
    run(2, -1, -1, 0, 23, "t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
